// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit core: serializes instruction fetches and MAR/MDR
// data accesses onto one unified RAM and returns one-cycle completion strobes.
module mem_responder #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_fetch,
    input  logic [15:0]   pc_out,
    input  logic          en_mar_pulse,
    input  logic [7:0]    offset_out,
    input  logic [1:0]    mdr_ctrl,
    input  logic [DW-1:0] regout,
    input  logic          en_ram,
    input  logic          wen_ram,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [DW-1:0] ins,
    output logic [DW-1:0] ram_data,
    output logic          en_in,
    output logic          en2,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {StIdle, StFetch, StRead, StWrite} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] mar_q;
    logic [AW-1:0] faddr_q, faddr_d, daddr_q, daddr_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] mdr_q, mdr_d, ins_q, ins_d;
    logic          en_in_q, en_in_d, en2_q, en2_d;
    logic          overrun_q, overrun_d;
    logic          accept;

    logic [DW-1:0] mem [2**AW];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [AW-1:0] pc_addr;
    logic          unused_addr_bits;

    // Address inputs are wider than AW; only the low bits select a word.
    assign pc_addr          = AW'(pc_out);
    assign unused_addr_bits = ^{pc_out, offset_out};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        faddr_d     = faddr_q;
        daddr_d     = daddr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        mdr_d       = mdr_q;
        ins_d       = ins_q;
        en_in_d     = 1'b0;
        en2_d       = 1'b0;
        overrun_d   = overrun_q;
        accept      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr;
        mem_wdata   = prog_data;

        unique case (state_q)
            StIdle: begin
                case (mdr_ctrl)
                    2'b01:   mdr_d = regout;
                    2'b10:   mdr_d = '0;
                    default: ;
                endcase
                if (pend_q || en_fetch) begin
                    accept  = 1'b1;
                    state_d = StFetch;
                    cnt_d   = 3'(RD_LAT - 1);
                    faddr_d = pend_q ? pend_addr_q : pc_addr;
                    // A fresh fetch that loses to the pending one stays queued.
                    pend_d  = pend_q && en_fetch;
                    if (pend_q && en_fetch) pend_addr_d = pc_addr;
                    if (en_ram) overrun_d = 1'b1;
                end else if (en_ram) begin
                    accept  = 1'b1;
                    daddr_d = mar_q;
                    if (wen_ram) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                        cnt_d   = 3'(RD_LAT - 1);
                    end
                end
                if (!accept && prog_we) mem_we = 1'b1;
            end
            StFetch: begin
                if (cnt_q == 3'd0) begin
                    ins_d   = mem[faddr_q];
                    en_in_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StRead: begin
                if (cnt_q == 3'd0) begin
                    mdr_d   = mem[daddr_q];
                    en2_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_waddr = daddr_q;
                mem_wdata = mdr_q;
                en2_d     = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            if (en_fetch) begin
                pend_d      = 1'b1;
                pend_addr_d = pc_addr;
            end
            if (en_ram) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mar_q       <= '0;
            faddr_q     <= '0;
            daddr_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            mdr_q       <= '0;
            ins_q       <= '0;
            en_in_q     <= 1'b0;
            en2_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (en_mar_pulse) mar_q <= AW'(offset_out);
            faddr_q     <= faddr_d;
            daddr_q     <= daddr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            mdr_q       <= mdr_d;
            ins_q       <= ins_d;
            en_in_q     <= en_in_d;
            en2_q       <= en2_d;
            overrun_q   <= overrun_d;
        end
    end

    // During reset only program loads reach memory; an in-flight write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (prog_we) mem[prog_addr] <= prog_data;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ins      = ins_q;
    assign ram_data = mdr_q;
    assign en_in    = en_in_q;
    assign en2      = en2_q;
    assign busy     = (state_q != StIdle);
    assign overrun  = overrun_q;

endmodule
